gate_equiv_checker: RTL and testbench
=====================================

# gate_equiv_checker

Sequential exhaustive-sweep checker that compares two implementations of the same combinational gate function. It drives every input vector to both implementations, waits a settle interval, and samples and compares their single-bit responses. It reports a mismatch count, the first failing vector, and pass/fail. It sits on the response side of the gate exercises: the stimulus source and result reader for paired gate-level and expression-level modules, such as a NOR built from NOR gates alongside `~a & ~b`.

## Interface
Parameters:
- N_IN, default 2: width of the stimulus vector (number of gate inputs); legal range 1..4.
- SETTLE, default 1: wait cycles after each new vector before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a sweep; sampled on rising clk; ignored while busy=1.
- x  output  N_IN  stimulus vector driven to both implementations.
- a  input  1  response of implementation A (e.g. gate-level).
- b  input  1  response of implementation B (e.g. expression-level).
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; stays high until the next accepted start or reset.
- pass  output  1  done=1 and err_count=0.
- err_count  output  N_IN+1  number of vectors where a≠b.
- first_fail  output  N_IN  first vector (ascending order) where a≠b; 0 if none.

## Operation
- States: IDLE, WAIT, SAMPLE, FINISH.
- Reset (rst_n=0, any state, takes effect immediately): state=IDLE; x, busy, done, pass, err_count, first_fail all 0.
- IDLE → WAIT on start=1: x←0; err_count, first_fail, done and pass cleared; busy←1; settle counter←SETTLE−1.
- FINISH behaves like IDLE: start=1 restarts the sweep; otherwise all results hold.
- WAIT: counter decrements each cycle. When counter=0, go to SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle): compare a and b as sampled on the edge that ends the cycle.
  - On mismatch: err_count←err_count+1. If err_count was 0, first_fail←x.
  - If x is all ones, go to FINISH: busy←0, done←1, pass←(final err_count==0).
  - Otherwise x←x+1, counter←SETTLE−1, go to WAIT.
- x never wraps during a sweep. err_count width N_IN+1 holds the maximum value 2^N_IN, so no saturation logic is needed.
- start while busy=1 is ignored entirely, with no restart and no effect on results.
- x holds its last value (all ones) in FINISH. x is 0 in IDLE after reset.

## Timing
- All outputs are registered; no combinational path from a, b or start to any output.
- a and b must be stable SETTLE cycles after x changes; they are sampled only at the end of SAMPLE.
- Start accepted at edge E0. Vector k is driven from E0+k·(SETTLE+1) and sampled at edge E0+(k+1)·(SETTLE+1).
- done, pass and busy=0 are visible after edge E0+2^N_IN·(SETTLE+1).
  - Defaults (N_IN=2, SETTLE=1): 8 cycles.
- busy rises at E0 and falls on the same edge done rises. busy and done are never both 1.
- err_count and first_fail update on SAMPLE edges, so intermediate values are visible during the sweep. They are final once done=1.
- Reset mid-sweep aborts with no partial-result retention. The first start after reset release behaves as from IDLE.

## Test plan
- a and b both driven by ~x[1]&~x[0] (matching NOR), defaults, one start pulse → done=1 eight cycles after the start edge; pass=1, err_count=0, first_fail=2'b00, x=2'b11.
- a=NOR, b=x[1]&x[0] (AND) → mismatches at 00 and 11; err_count=2, first_fail=2'b00, pass=0.
- a=NOR, b=~a (always different) → err_count=4, first_fail=2'b00, pass=0. Then a second start with b=a → err_count=0, pass=1 (results cleared on restart).
- a=NOR, b=NOR xor (x==2'b11) → err_count=1, first_fail=2'b11, pass=0.
- rst_n pulsed low during cycle 3 of a sweep → busy, done, x, err_count and first_fail go to 0 immediately without a clock edge. A fresh start then completes in 8 cycles with correct results.
- start held high through the whole sweep, SETTLE=3 → no restart; done at 16 cycles; each x value is held for 4 cycles.

Source files
------------

// File: rtl/gate_equiv_checker.sv
// Exhaustive sweep that drives every input vector to two gate implementations,
// waits SETTLE cycles, then compares their responses and records the results.
module gate_equiv_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    output logic [N_IN-1:0] x_o,
    input  logic            a_i,
    input  logic            b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN:0]   err_count_o,
    output logic [N_IN-1:0] first_fail_o
);

    localparam int          EW          = N_IN + 1;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        FINISH
    } state_t;

    state_t          state_q,     state_d;
    logic [N_IN-1:0] x_q,         x_d;
    logic [3:0]      settleCnt_q, settleCnt_d;
    logic            busy_q,      busy_d;
    logic            done_q,      done_d;
    logic            pass_q,      pass_d;
    logic [EW-1:0]   errCount_q,  errCount_d;
    logic [N_IN-1:0] firstFail_q, firstFail_d;

    logic            mismatch;
    logic [EW-1:0]   errNext;
    logic            lastVec;

    assign mismatch = a_i ^ b_i;
    assign errNext  = errCount_q + EW'(mismatch);
    assign lastVec  = &x_q;

    // State and result registers; reset clears everything including the stimulus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            settleCnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCount_q  <= '0;
            firstFail_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            settleCnt_q <= settleCnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            errCount_q  <= errCount_d;
            firstFail_q <= firstFail_d;
        end
    end

    // Sweep control; start is only honoured from IDLE or FINISH.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        settleCnt_d = settleCnt_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        errCount_d  = errCount_q;
        firstFail_d = firstFail_q;

        case (state_q)
            IDLE, FINISH: begin
                if (start_i) begin
                    state_d     = WAIT;
                    x_d         = '0;
                    settleCnt_d = SETTLE_LOAD;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    errCount_d  = '0;
                    firstFail_d = '0;
                end
            end

            WAIT: begin
                if (settleCnt_q == 4'd0) begin
                    state_d = SAMPLE;
                end else begin
                    settleCnt_d = settleCnt_q - 4'd1;
                end
            end

            SAMPLE: begin
                errCount_d = errNext;
                if (mismatch && (errCount_q == '0)) begin
                    firstFail_d = x_q;
                end
                if (lastVec) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errNext == '0);
                end else begin
                    state_d     = WAIT;
                    x_d         = x_q + N_IN'(1);
                    settleCnt_d = SETTLE_LOAD;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign x_o          = x_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_count_o  = errCount_q;
    assign first_fail_o = firstFail_q;

endmodule

// File: tb/tb_gate_equiv_checker.sv
// Bench for gate_equiv_checker: two instances (SETTLE=1 and SETTLE=3) whose
// a/b inputs are truth tables indexed by x, checked every cycle against a sweep model.
module tb_gate_equiv_checker;

    localparam int S0 = 1;
    localparam int S1 = 3;
    localparam logic [15:0] T_NOR  = 16'h0001;
    localparam logic [15:0] T_AND  = 16'h0008;
    localparam logic [15:0] T_NNOR = 16'h000E;
    localparam logic [15:0] T_NX11 = 16'h0009;

    logic clk;
    logic rst_n;
    logic startS [2];
    logic [15:0] tabA [2];
    logic [15:0] tabB [2];

    logic [1:0] x0, x1, ff0, ff1;
    logic [2:0] err0, err1;
    logic busy0, busy1, done0, done1, pass0, pass1;
    logic a0, b0, a1, b1;

    int nCompared;
    int nMismatched;
    bit checkEn;

    bit          started [2];
    int          el      [2];
    logic [15:0] latA    [2];
    logic [15:0] latB    [2];

    assign a0 = tabA[0][x0];
    assign b0 = tabB[0][x0];
    assign a1 = tabA[1][x1];
    assign b1 = tabB[1][x1];

    gate_equiv_checker #(.N_IN(2), .SETTLE(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(startS[0]), .x_o(x0),
        .a_i(a0), .b_i(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .err_count_o(err0), .first_fail_o(ff0)
    );

    gate_equiv_checker #(.N_IN(2), .SETTLE(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(startS[1]), .x_o(x1),
        .a_i(a1), .b_i(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .err_count_o(err1), .first_fail_o(ff1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settleOf(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic int totalOf(input int i);
        return 4 * (settleOf(i) + 1);
    endfunction

    function automatic bit modelBusy(input int i);
        return started[i] && (el[i] < totalOf(i));
    endfunction

    // Expected outputs from the number of edges elapsed since the accepted start.
    function automatic void expectOf(input int i, output int ex, output int eb,
                                     output int ed, output int ep, output int ee,
                                     output int ef);
        int smp;
        bit found;
        ex = 0; eb = 0; ed = 0; ep = 0; ee = 0; ef = 0;
        if (started[i]) begin
            smp = el[i] / (settleOf(i) + 1);
            if (smp > 4) smp = 4;
            ex = (smp > 3) ? 3 : smp;
            eb = (el[i] < totalOf(i)) ? 1 : 0;
            ed = 1 - eb;
            found = 1'b0;
            for (int k = 0; k < smp; k++) begin
                if (latA[i][k] != latB[i][k]) begin
                    if (!found) ef = k;
                    found = 1'b1;
                    ee++;
                end
            end
            ep = (ed == 1 && ee == 0) ? 1 : 0;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model advance: latch the tables whenever a start is accepted.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                started[i] <= 1'b0;
                el[i]      <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (startS[i] && !modelBusy(i)) begin
                    started[i] <= 1'b1;
                    el[i]      <= 0;
                    latA[i]    <= tabA[i];
                    latB[i]    <= tabB[i];
                end else if (started[i] && el[i] < 1000) begin
                    el[i] <= el[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int ex, eb, ed, ep, ee, ef;
        if (checkEn && rst_n) begin
            expectOf(0, ex, eb, ed, ep, ee, ef);
            checkOutput("dut0.x",    32'(x0),    32'(ex));
            checkOutput("dut0.busy", 32'(busy0), 32'(eb));
            checkOutput("dut0.done", 32'(done0), 32'(ed));
            checkOutput("dut0.pass", 32'(pass0), 32'(ep));
            checkOutput("dut0.err",  32'(err0),  32'(ee));
            checkOutput("dut0.ff",   32'(ff0),   32'(ef));
            expectOf(1, ex, eb, ed, ep, ee, ef);
            checkOutput("dut1.x",    32'(x1),    32'(ex));
            checkOutput("dut1.busy", 32'(busy1), 32'(eb));
            checkOutput("dut1.done", 32'(done1), 32'(ed));
            checkOutput("dut1.pass", 32'(pass1), 32'(ep));
            checkOutput("dut1.err",  32'(err1),  32'(ee));
            checkOutput("dut1.ff",   32'(ff1),   32'(ef));
        end
    end

    // One sweep on instance i; returns cycles from the start edge to done.
    task automatic applyStimulus(input int i, input logic [15:0] ta,
                                 input logic [15:0] tb, input bit hold,
                                 output int cycles);
        bit got;
        @(negedge clk);
        tabA[i] = ta;
        tabB[i] = tb;
        startS[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) startS[i] = 1'b0;
        cycles = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if ((i == 0) ? done0 : done1) got = 1'b1;
            else cycles++;
        end
        startS[i] = 1'b0;
        if (!got) checkOutput("sweep_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkFinal(input string tag, input int i, input int eErr,
                              input int eFf, input int ePass);
        checkOutput({tag, ".err"},  32'((i == 0) ? err0 : err1),   32'(eErr));
        checkOutput({tag, ".ff"},   32'((i == 0) ? ff0 : ff1),     32'(eFf));
        checkOutput({tag, ".pass"}, 32'((i == 0) ? pass0 : pass1), 32'(ePass));
        checkOutput({tag, ".x"},    32'((i == 0) ? x0 : x1),       32'd3);
        checkOutput({tag, ".busy"}, 32'((i == 0) ? busy0 : busy1), 32'd0);
    endtask

    // Free-running random starts, table swaps between sweeps and occasional resets.
    task automatic randomPhase(input int nCycles);
        for (int c = 0; c < nCycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!modelBusy(i) && ($urandom % 3 == 0)) begin
                    tabA[i] = 16'($urandom);
                    tabB[i] = ($urandom % 3 == 0) ? tabA[i] : tabA[i] ^ 16'(1 << ($urandom % 4));
                    if ($urandom % 4 == 0) tabB[i] = 16'($urandom);
                end
                startS[i] = ($urandom % 4 == 0);
            end
            if ($urandom % 150 == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        startS[0] = 1'b0;
        startS[1] = 1'b0;
    endtask

    initial begin
        int cyc;
        nCompared   = 0;
        nMismatched = 0;
        checkEn     = 1'b0;
        rst_n       = 1'b0;
        startS[0]   = 1'b0;
        startS[1]   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tabA[i] = T_NOR;
            tabB[i] = T_NOR;
        end
        repeat (3) @(negedge clk);
        checkOutput("rst.x",    32'(x0),    32'd0);
        checkOutput("rst.busy", 32'(busy0), 32'd0);
        checkOutput("rst.done", 32'(done0), 32'd0);
        checkOutput("rst.pass", 32'(pass0), 32'd0);
        checkOutput("rst.err",  32'(err0),  32'd0);
        checkOutput("rst.ff",   32'(ff0),   32'd0);
        rst_n   = 1'b1;
        checkEn = 1'b1;

        $display("[TB] matching NOR implementations");
        applyStimulus(0, T_NOR, T_NOR, 1'b0, cyc);
        checkOutput("nor_nor.cycles", 32'(cyc), 32'd8);
        checkFinal("nor_nor", 0, 0, 0, 1);

        $display("[TB] NOR against AND");
        applyStimulus(0, T_NOR, T_AND, 1'b0, cyc);
        checkFinal("nor_and", 0, 2, 0, 0);

        $display("[TB] always-different pair, then restart with equal pair");
        applyStimulus(0, T_NOR, T_NNOR, 1'b0, cyc);
        checkFinal("nor_not", 0, 4, 0, 0);
        applyStimulus(0, T_NOR, T_NOR, 1'b0, cyc);
        checkFinal("restart", 0, 0, 0, 1);

        $display("[TB] single mismatch at the last vector");
        applyStimulus(0, T_NOR, T_NX11, 1'b0, cyc);
        checkFinal("last_only", 0, 1, 3, 0);

        $display("[TB] asynchronous reset mid-sweep");
        @(negedge clk);
        tabA[0] = T_NOR;
        tabB[0] = T_AND;
        startS[0] = 1'b1;
        @(posedge clk);
        #1 startS[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst.x",    32'(x0),    32'd0);
        checkOutput("midrst.busy", 32'(busy0), 32'd0);
        checkOutput("midrst.done", 32'(done0), 32'd0);
        checkOutput("midrst.err",  32'(err0),  32'd0);
        checkOutput("midrst.ff",   32'(ff0),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, T_NOR, T_AND, 1'b0, cyc);
        checkOutput("after_rst.cycles", 32'(cyc), 32'd8);
        checkFinal("after_rst", 0, 2, 0, 0);

        $display("[TB] start held through a SETTLE=3 sweep");
        applyStimulus(1, T_NOR, T_AND, 1'b1, cyc);
        checkOutput("held.cycles", 32'(cyc), 32'd16);
        checkFinal("held", 1, 2, 0, 0);

        $display("[TB] randomized phase");
        randomPhase(3000);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
